// File: rtl/stream_mux_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_rr
//   N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes on
//   every input and on the output. The channel is chosen either by software
//   (mode=0, sel picks the channel) or by a round-robin arbiter over the
//   channels that are currently valid (mode=1). The output is a single
//   register stage: 1-cycle latency, one beat per cycle sustained.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_data    N*WIDTH packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit set)
//   mode       0 = software select, 1 = round robin
//   sel        selected channel in select mode, ignored in round robin
//   out_data   registered output data
//   out_valid  registered output valid
//   out_ready  downstream ready
//   out_chan   registered index of the channel that sourced out_data
// ---------------------------------------------------------------------------
module stream_mux_rr #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_chan
);

    logic [WIDTH-1:0] data_p0;
    logic             vld_p0;
    logic [SELW-1:0]  chan_p0;
    logic [SELW-1:0]  ptr_p0;

    logic             load;
    logic             gnt_valid;
    logic [SELW-1:0]  gnt;
    logic [WIDTH-1:0] gnt_data;

    // The register takes a new beat when empty or when being drained now.
    assign load = rst_n & (~vld_p0 | out_ready);

    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        gnt_data  = '0;
        if (!mode) begin
            // An out-of-range sel matches no channel, so nothing is granted.
            for (int i = 0; i < N; i++) begin
                if (sel == SELW'(i)) begin
                    gnt       = SELW'(i);
                    gnt_valid = in_valid[i];
                end
            end
        end else begin
            // Scan from the farthest candidate back to ptr+1 so the last
            // hit written is the nearest valid channel after the pointer.
            for (int k = N; k >= 1; k--) begin
                if (in_valid[(int'(ptr_p0) + k) % N]) begin
                    gnt       = SELW'((int'(ptr_p0) + k) % N);
                    gnt_valid = 1'b1;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (gnt == SELW'(i)) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = load & gnt_valid & (gnt == SELW'(i));
        end
    end

    // ---- stage p0: output register and round-robin pointer ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            chan_p0 <= '0;
            ptr_p0  <= SELW'(N - 1);
        end else begin
            if (load) begin
                vld_p0 <= gnt_valid;
                if (gnt_valid) begin
                    data_p0 <= gnt_data;
                    chan_p0 <= gnt;
                end
            end
            // Pointer only moves on round-robin transfers so select mode
            // does not disturb the fairness order.
            if (load && gnt_valid && mode) begin
                ptr_p0 <= gnt;
            end
        end
    end

    assign out_data  = data_p0;
    assign out_valid = vld_p0;
    assign out_chan  = chan_p0;

endmodule

// File: tb/tb_stream_mux_rr.sv
// ---------------------------------------------------------------------------
// tb_stream_mux_rr
//   Self-checking bench for stream_mux_rr. Main instance uses N=4, WIDTH=32;
//   a second instance with N=6, WIDTH=8 exercises select values that are
//   valid-less or beyond the channel count. Expected output beats are pushed
//   to a scoreboard queue when the transfer is driven and popped when the
//   beat appears on the output.
// ---------------------------------------------------------------------------
module tb_stream_mux_rr;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int BW = 8;
    localparam int BN = 6;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [1:0]     sel;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     out_chan;

    logic [BN*BW-1:0] b_in_data;
    logic [BN-1:0]    b_in_valid;
    logic [BN-1:0]    b_in_ready;
    logic             b_mode;
    logic [2:0]       b_sel;
    logic [BW-1:0]    b_out_data;
    logic             b_out_valid;
    logic             b_out_ready;
    logic [2:0]       b_out_chan;

    int errors = 0;
    int checks = 0;
    logic [W+1:0] exp_q[$];
    logic [W+1:0] e;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan)
    );

    stream_mux_rr #(.WIDTH(BW), .N(BN)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .mode      (b_mode),
        .sel       (b_sel),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_chan  (b_out_chan)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_words();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
    endtask

    function automatic logic [W-1:0] word(int i);
        return in_data[i*W +: W];
    endfunction

    task automatic push_beat(int ch);
        exp_q.push_back({2'(ch), word(ch)});
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b1; sel = '0; out_ready = 1'b1; in_valid = 4'hF;
        rand_words();
        b_in_data = '0; b_in_valid = '0; b_mode = 1'b0; b_sel = '0; b_out_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h, expected 0", out_data); end
        checks++;
        if (out_chan !== 2'd0) begin errors++; $display("FAIL reset_chan: got %0d, expected 0", out_chan); end
        checks++;
        if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b, expected 0000", in_ready); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b, expected 0001", in_ready); end
        push_beat(0);
        tick();
        if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL reset_first_beat: scoreboard empty");
        end else begin
            e = exp_q.pop_front(); checks++;
            if (out_valid !== 1'b1 || {out_chan, out_data} !== e) begin
                errors++;
                $display("FAIL reset_first_beat: got v=%b ch=%0d d=%h, expected v=1 ch=%0d d=%h", out_valid, out_chan, out_data, e[W+1:W], e[W-1:0]);
            end
        end
        in_valid = '0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_drain: got %b, expected 0", out_valid); end
    endtask

    task automatic test_sel_basic();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100;
        rand_words();
        in_data[2*W +: W] = 32'hDEADBEEF;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin errors++; $display("FAIL sel_in_ready: got %b, expected 0100", in_ready); end
        push_beat(2);
        tick();
        if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL sel_beat: scoreboard empty");
        end else begin
            e = exp_q.pop_front(); checks++;
            if (out_valid !== 1'b1 || {out_chan, out_data} !== e) begin
                errors++;
                $display("FAIL sel_beat: got v=%b ch=%0d d=%h, expected v=1 ch=%0d d=%h", out_valid, out_chan, out_data, e[W+1:W], e[W-1:0]);
            end
        end
        // Selected channel idle, the others valid: nothing may be granted.
        in_valid = 4'b1011;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin errors++; $display("FAIL sel_other_valid: got %b, expected 0000", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL sel_no_transfer: got %b, expected 0", out_valid); end
        in_valid = '0;
    endtask

    task automatic test_sel_range();
        logic [BW-1:0] bexp;
        b_mode = 1'b0; b_sel = 3'd5; b_in_valid = 6'b011111;
        b_in_data = 48'({$urandom, $urandom});
        #1;
        checks++;
        if (b_in_ready !== 6'b000000) begin errors++; $display("FAIL sel5_idle_ready: got %b, expected 000000", b_in_ready); end
        tick();
        checks++;
        if (b_out_valid !== 1'b0) begin errors++; $display("FAIL sel5_idle_valid: got %b, expected 0", b_out_valid); end
        b_sel = 3'd6; b_in_valid = 6'h3F;
        #1;
        checks++;
        if (b_in_ready !== 6'b000000) begin errors++; $display("FAIL sel_oor_ready: got %b, expected 000000", b_in_ready); end
        tick();
        checks++;
        if (b_out_valid !== 1'b0) begin errors++; $display("FAIL sel_oor_valid: got %b, expected 0", b_out_valid); end
        b_sel = 3'd5; b_in_valid = 6'b100000;
        #1;
        bexp = b_in_data[5*BW +: BW];
        checks++;
        if (b_in_ready !== 6'b100000) begin errors++; $display("FAIL sel5_ready: got %b, expected 100000", b_in_ready); end
        tick();
        checks++;
        if (b_out_valid !== 1'b1 || b_out_chan !== 3'd5 || b_out_data !== bexp) begin
            errors++;
            $display("FAIL sel5_beat: got v=%b ch=%0d d=%h, expected v=1 ch=5 d=%h", b_out_valid, b_out_chan, b_out_data, bexp);
        end
        b_in_valid = '0;
    endtask

    task automatic test_rr_fairness();
        rst_n = 1'b0; in_valid = '0;
        tick();
        rst_n = 1'b1; mode = 1'b1; out_ready = 1'b1; in_valid = 4'hF;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++; $display("FAIL rr_fair_beat%0d: scoreboard empty", k - 1);
                end else begin
                    e = exp_q.pop_front(); checks++;
                    if (out_valid !== 1'b1 || {out_chan, out_data} !== e) begin
                        errors++;
                        $display("FAIL rr_fair_beat%0d: got v=%b ch=%0d d=%h, expected v=1 ch=%0d d=%h", k - 1, out_valid, out_chan, out_data, e[W+1:W], e[W-1:0]);
                    end
                end
            end
            if (k < 8) begin
                rand_words();
                #1;
                checks++;
                if (in_ready !== 4'(1 << (k % N))) begin errors++; $display("FAIL rr_fair_ready%0d: got %b, expected %b", k, in_ready, 4'(1 << (k % N))); end
                push_beat(k % N);
                tick();
            end
        end
        in_valid = '0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_fair_drain: got %b, expected 0", out_valid); end
    endtask

    task automatic test_rr_sparse();
        logic [3:0] vpat [7] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0010, 4'b0010, 4'b0010};
        int         ech  [7] = '{1, 3, 1, 3, 1, 1, 1};
        mode = 1'b1; out_ready = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++; $display("FAIL rr_sparse_beat%0d: scoreboard empty", k - 1);
                end else begin
                    e = exp_q.pop_front(); checks++;
                    if (out_valid !== 1'b1 || {out_chan, out_data} !== e) begin
                        errors++;
                        $display("FAIL rr_sparse_beat%0d: got v=%b ch=%0d d=%h, expected v=1 ch=%0d d=%h", k - 1, out_valid, out_chan, out_data, e[W+1:W], e[W-1:0]);
                    end
                end
            end
            if (k < 7) begin
                in_valid = vpat[k];
                rand_words();
                #1;
                checks++;
                if (in_ready !== 4'(1 << ech[k])) begin errors++; $display("FAIL rr_sparse_ready%0d: got %b, expected %b", k, in_ready, 4'(1 << ech[k])); end
                push_beat(ech[k]);
                tick();
            end
        end
        in_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [W+1:0] held;
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'hF;
        rand_words();
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_first_ready: got %b, expected 0100", in_ready); end
        push_beat(2);
        tick();
        held = '0;
        if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL bp_first_beat: scoreboard empty");
        end else begin
            e = exp_q.pop_front(); checks++; held = e;
            if (out_valid !== 1'b1 || {out_chan, out_data} !== e) begin
                errors++;
                $display("FAIL bp_first_beat: got v=%b ch=%0d d=%h, expected v=1 ch=%0d d=%h", out_valid, out_chan, out_data, e[W+1:W], e[W-1:0]);
            end
        end
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rand_words();
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready%0d: got %b, expected 0000", k, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || {out_chan, out_data} !== held) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b ch=%0d d=%h, expected v=1 ch=%0d d=%h", k, out_valid, out_chan, out_data, held[W+1:W], held[W-1:0]);
            end
        end
        out_ready = 1'b1;
        rand_words();
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin errors++; $display("FAIL bp_refill_ready: got %b, expected 1000", in_ready); end
        push_beat(3);
        tick();
        if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL bp_refill_beat: scoreboard empty");
        end else begin
            e = exp_q.pop_front(); checks++;
            if (out_valid !== 1'b1 || {out_chan, out_data} !== e) begin
                errors++;
                $display("FAIL bp_refill_beat: got v=%b ch=%0d d=%h, expected v=1 ch=%0d d=%h", out_valid, out_chan, out_data, e[W+1:W], e[W-1:0]);
            end
        end
        in_valid = '0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b, expected 0", out_valid); end
    endtask

    task automatic test_mode_switch_reset();
        logic       mpat [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] vpat [5] = '{4'b0010, 4'hF, 4'hF, 4'hF, 4'hF};
        int         ech  [5] = '{1, 0, 0, 0, 2};
        sel = 2'd0; out_ready = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++; $display("FAIL mode_sw_beat%0d: scoreboard empty", k - 1);
                end else begin
                    e = exp_q.pop_front(); checks++;
                    if (out_valid !== 1'b1 || {out_chan, out_data} !== e) begin
                        errors++;
                        $display("FAIL mode_sw_beat%0d: got v=%b ch=%0d d=%h, expected v=1 ch=%0d d=%h", k - 1, out_valid, out_chan, out_data, e[W+1:W], e[W-1:0]);
                    end
                end
            end
            if (k < 5) begin
                mode = mpat[k]; in_valid = vpat[k];
                rand_words();
                #1;
                checks++;
                if (in_ready !== 4'(1 << ech[k])) begin errors++; $display("FAIL mode_sw_ready%0d: got %b, expected %b", k, in_ready, 4'(1 << ech[k])); end
                push_beat(ech[k]);
                tick();
            end
        end
        // A beat is held (channel 2) and all channels are valid; reset now.
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin errors++; $display("FAIL rst_mid_ready: got %b, expected 0000", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_chan !== 2'd0 || out_data !== '0) begin
            errors++;
            $display("FAIL rst_mid_out: got v=%b ch=%0d d=%h, expected v=0 ch=0 d=0", out_valid, out_chan, out_data);
        end
        rst_n = 1'b1;
        rand_words();
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin errors++; $display("FAIL rst_mid_ptr: got %b, expected 0001", in_ready); end
        push_beat(0);
        tick();
        if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL rst_mid_beat: scoreboard empty");
        end else begin
            e = exp_q.pop_front(); checks++;
            if (out_valid !== 1'b1 || {out_chan, out_data} !== e) begin
                errors++;
                $display("FAIL rst_mid_beat: got v=%b ch=%0d d=%h, expected v=1 ch=%0d d=%h", out_valid, out_chan, out_data, e[W+1:W], e[W-1:0]);
            end
        end
        in_valid = '0;
        tick();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d pending, expected 0", exp_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sel_basic();
        test_sel_range();
        test_rr_fairness();
        test_rr_sparse();
        test_backpressure();
        test_mode_switch_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
